// File: rtl/voter_pkg.sv
// Shared types and constants for the TMR voter and its per-replica fault monitors.
package voter_pkg;

    typedef enum logic [1:0] {
        TRK_OK      = 2'd0,
        TRK_SUSPECT = 2'd1,
        TRK_FAULT   = 2'd2
    } trk_state_e;

    localparam int IDX_A = 2;
    localparam int IDX_B = 1;
    localparam int IDX_C = 0;

    // True when at least two of the three flags are set (2-of-3 majority of the flags).
    function automatic logic at_least_two(input logic [2:0] m);
        return (m[0] & m[1]) | (m[0] & m[2]) | (m[1] & m[2]);
    endfunction

endpackage

// File: rtl/voter_replica_mon.sv
// One replica's persistent-fault tracker (OK/SUSPECT/FAULT) plus its saturating mismatch
// counter, which exists only when VOTER_ERR_CNT_EN is defined.
module voter_replica_mon
    import voter_pkg::*;
#(
    parameter int CNT_WIDTH = 8,
    parameter int PERSIST   = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 clr,
    input  logic                 mis_i,
    output logic                 fault_o,
    output logic [CNT_WIDTH-1:0] err_cnt_o
);

    localparam int RUN_W = $clog2(PERSIST + 1);
    localparam logic [RUN_W-1:0] RUN_LIMIT = RUN_W'(PERSIST);

    trk_state_e       r_state;
    trk_state_e       w_state_nxt;
    logic [RUN_W-1:0] r_run;
    logic [RUN_W-1:0] w_run_nxt;
    logic [RUN_W-1:0] w_run_inc;

    assign w_run_inc = r_run + RUN_W'(1);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= TRK_OK;
            r_run   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_run   <= w_run_nxt;
        end
    end

    // Disabled cycles leave the tracker untouched, so a SUSPECT run survives gaps in en.
    always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        if (clr) begin
            w_state_nxt = TRK_OK;
            w_run_nxt   = '0;
        end else if (en) begin
            case (r_state)
                TRK_OK: begin
                    if (mis_i) begin
                        w_run_nxt   = RUN_W'(1);
                        w_state_nxt = (PERSIST == 1) ? TRK_FAULT : TRK_SUSPECT;
                    end
                end
                TRK_SUSPECT: begin
                    if (mis_i) begin
                        w_run_nxt = w_run_inc;
                        if (w_run_inc == RUN_LIMIT) w_state_nxt = TRK_FAULT;
                    end else begin
                        w_state_nxt = TRK_OK;
                        w_run_nxt   = '0;
                    end
                end
                TRK_FAULT: w_state_nxt = TRK_FAULT;
                default: begin
                    w_state_nxt = TRK_OK;
                    w_run_nxt   = '0;
                end
            endcase
        end
    end

    assign fault_o = (r_state == TRK_FAULT);

`ifdef VOTER_ERR_CNT_EN
    logic [CNT_WIDTH-1:0] r_err_cnt;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_cnt <= '0;
        end else if (clr) begin
            r_err_cnt <= '0;
        end else if (en && mis_i && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + CNT_WIDTH'(1);
        end
    end

    assign err_cnt_o = r_err_cnt;
`else
    assign err_cnt_o = '0;
`endif

endmodule

// File: rtl/voter_tmr_monitor.sv
// Registered bitwise 2-of-3 voter with per-replica mismatch flags and fault monitors.
// Error counters are compiled in only when VOTER_ERR_CNT_EN is defined.
module voter_tmr_monitor
    import voter_pkg::*;
#(
    parameter int WIDTH     = 6,
    parameter int CNT_WIDTH = 8,
    parameter int PERSIST   = 4
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 en,
    input  logic                 clr,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [WIDTH-1:0]     C,
    output logic [WIDTH-1:0]     Q,
    output logic                 q_valid,
    output logic [2:0]           mis,
    output logic                 multi,
    output logic [CNT_WIDTH-1:0] err_cnt_a,
    output logic [CNT_WIDTH-1:0] err_cnt_b,
    output logic [CNT_WIDTH-1:0] err_cnt_c,
    output logic [2:0]           fault
);

    logic [WIDTH-1:0] w_maj;
    logic [2:0]       w_mis;
    logic [WIDTH-1:0] r_q;
    logic             r_q_valid;
    logic [2:0]       r_mis;
    logic             r_multi;

    assign w_maj        = (A & B) | (A & C) | (B & C);
    assign w_mis[IDX_A] = (A != w_maj);
    assign w_mis[IDX_B] = (B != w_maj);
    assign w_mis[IDX_C] = (C != w_maj);

    // Q holds across disabled cycles; the mismatch flags describe only the current sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_q       <= '0;
            r_q_valid <= 1'b0;
            r_mis     <= '0;
            r_multi   <= 1'b0;
        end else begin
            r_q_valid <= en;
            if (en) begin
                r_q     <= w_maj;
                r_mis   <= w_mis;
                r_multi <= at_least_two(w_mis);
            end else begin
                r_mis   <= '0;
                r_multi <= 1'b0;
            end
        end
    end

    assign Q       = r_q;
    assign q_valid = r_q_valid;
    assign mis     = r_mis;
    assign multi   = r_multi;

    voter_replica_mon #(.CNT_WIDTH(CNT_WIDTH), .PERSIST(PERSIST)) u_mon_a (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .mis_i(w_mis[IDX_A]),
        .fault_o(fault[IDX_A]), .err_cnt_o(err_cnt_a)
    );

    voter_replica_mon #(.CNT_WIDTH(CNT_WIDTH), .PERSIST(PERSIST)) u_mon_b (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .mis_i(w_mis[IDX_B]),
        .fault_o(fault[IDX_B]), .err_cnt_o(err_cnt_b)
    );

    voter_replica_mon #(.CNT_WIDTH(CNT_WIDTH), .PERSIST(PERSIST)) u_mon_c (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .mis_i(w_mis[IDX_C]),
        .fault_o(fault[IDX_C]), .err_cnt_o(err_cnt_c)
    );

endmodule

// File: tb/tb_voter_tmr_monitor.sv
// Directed bench for voter_tmr_monitor: default-width instance plus a 2-bit-counter instance
// sharing the same stimulus; counter expectations follow VOTER_ERR_CNT_EN.
module tb_voter_tmr_monitor;
    import voter_pkg::*;

`ifdef VOTER_ERR_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic       clk;
    logic       rstn;
    logic       en;
    logic       clr;
    logic [5:0] a, b, c;
    logic [5:0] q;
    logic       q_valid;
    logic [2:0] mis;
    logic       multi;
    logic [7:0] cnt_a, cnt_b, cnt_c;
    logic [2:0] fault;
    logic [5:0] s_q;
    logic       s_q_valid;
    logic [2:0] s_mis;
    logic       s_multi;
    logic [1:0] s_cnt_a, s_cnt_b, s_cnt_c;
    logic [2:0] s_fault;

    int n_vec;
    int n_fail;

    voter_tmr_monitor #(.WIDTH(6), .CNT_WIDTH(8), .PERSIST(4)) dut (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .A(a), .B(b), .C(c),
        .Q(q), .q_valid(q_valid), .mis(mis), .multi(multi),
        .err_cnt_a(cnt_a), .err_cnt_b(cnt_b), .err_cnt_c(cnt_c), .fault(fault)
    );

    voter_tmr_monitor #(.WIDTH(6), .CNT_WIDTH(2), .PERSIST(4)) dut_s (
        .clk(clk), .rstn(rstn), .en(en), .clr(clr), .A(a), .B(b), .C(c),
        .Q(s_q), .q_valid(s_q_valid), .mis(s_mis), .multi(s_multi),
        .err_cnt_a(s_cnt_a), .err_cnt_b(s_cnt_b), .err_cnt_c(s_cnt_c), .fault(s_fault)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] ec(input int v);
        return CNT_EN ? 32'(v) : 32'd0;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive inputs, then sample 1 ns after the next rising edge.
    task automatic step(input logic e, input logic cl, input logic [5:0] va,
                        input logic [5:0] vb, input logic [5:0] vc);
        en  = e;
        clr = cl;
        a   = va;
        b   = vb;
        c   = vc;
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec  = 0;
        n_fail = 0;
        rstn = 1'b0;
        en   = 1'b0;
        clr  = 1'b0;
        a = '0; b = '0; c = '0;
        #1;
        check("rst_q", 32'(q), 32'h0);
        check("rst_qv", 32'(q_valid), 32'h0);
        check("rst_mis", 32'(mis), 32'h0);
        check("rst_fault", 32'(fault), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;

        // All replicas agree
        step(1'b1, 1'b0, 6'h2A, 6'h2A, 6'h2A);
        check("eq_q", 32'(q), 32'h2A);
        check("eq_qv", 32'(q_valid), 32'h1);
        check("eq_mis", 32'(mis), 32'h0);
        check("eq_multi", 32'(multi), 32'h0);
        check("eq_cnt_a", 32'(cnt_a), ec(0));

        // Single upset on A
        step(1'b1, 1'b0, 6'h3F, 6'h00, 6'h00);
        check("upA_q", 32'(q), 32'h00);
        check("upA_mis", 32'(mis), 32'h4);
        check("upA_cnt_a", 32'(cnt_a), ec(1));
        check("upA_state", 32'(dut.u_mon_a.r_state), 32'(TRK_SUSPECT));
        check("upA_fault", 32'(fault), 32'h0);

        step(1'b1, 1'b0, 6'h15, 6'h15, 6'h15);
        check("recA_q", 32'(q), 32'h15);
        check("recA_mis", 32'(mis), 32'h0);
        check("recA_state", 32'(dut.u_mon_a.r_state), 32'(TRK_OK));
        check("recA_cnt_a", 32'(cnt_a), ec(1));

        // B persistently wrong, with a disabled gap after the second sample
        step(1'b1, 1'b0, 6'h11, 6'h13, 6'h11);
        check("b1_q", 32'(q), 32'h11);
        check("b1_mis", 32'(mis), 32'h2);
        step(1'b1, 1'b0, 6'h11, 6'h13, 6'h11);
        check("b2_stateB", 32'(dut.u_mon_b.r_state), 32'(TRK_SUSPECT));
        step(1'b0, 1'b0, 6'h3F, 6'h3F, 6'h3F);
        check("gap_q_hold", 32'(q), 32'h11);
        check("gap_qv", 32'(q_valid), 32'h0);
        check("gap_mis", 32'(mis), 32'h0);
        check("gap_stateB", 32'(dut.u_mon_b.r_state), 32'(TRK_SUSPECT));
        check("gap_cnt_b", 32'(cnt_b), ec(2));
        step(1'b1, 1'b0, 6'h11, 6'h13, 6'h11);
        check("b3_fault", 32'(fault), 32'h0);
        step(1'b1, 1'b0, 6'h11, 6'h13, 6'h11);
        check("b4_fault", 32'(fault), 32'h2);
        check("b4_cnt_b", 32'(cnt_b), ec(4));

        // Two replicas wrong in different bits
        step(1'b1, 1'b0, 6'h01, 6'h02, 6'h00);
        check("multi_q", 32'(q), 32'h00);
        check("multi_mis", 32'(mis), 32'h6);
        check("multi_flag", 32'(multi), 32'h1);
        check("multi_cnt_a", 32'(cnt_a), ec(2));
        check("multi_fault_sticky", 32'(fault), 32'h2);

        // Clear everything
        step(1'b1, 1'b1, 6'h00, 6'h00, 6'h00);
        check("clr_fault", 32'(fault), 32'h0);
        check("clr_cnt_b", 32'(cnt_b), ec(0));
        check("clr_stateA", 32'(dut.u_mon_a.r_state), 32'(TRK_OK));

        // C wrong for 6 samples: 2-bit counter saturates at 3
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 6'h0A, 6'h0A, 6'h0B);
        check("sat_s_cnt_c", 32'(s_cnt_c), ec(3));
        check("sat_cnt_c", 32'(cnt_c), ec(6));
        check("sat_fault", 32'(fault), 32'h1);
        check("sat_s_fault", 32'(s_fault), 32'h1);

        // Clear wins over a mismatch in the same cycle; Q still updates
        step(1'b1, 1'b1, 6'h2C, 6'h2C, 6'h00);
        check("clrmis_q", 32'(q), 32'h2C);
        check("clrmis_mis", 32'(mis), 32'h1);
        check("clrmis_cnt_c", 32'(cnt_c), ec(0));
        check("clrmis_s_cnt_c", 32'(s_cnt_c), ec(0));
        check("clrmis_fault", 32'(fault), 32'h0);

        step(1'b1, 1'b0, 6'h2C, 6'h2C, 6'h00);
        check("post_clr_cnt_c", 32'(cnt_c), ec(1));
        check("post_clr_stateC", 32'(dut.u_mon_c.r_state), 32'(TRK_SUSPECT));

        // Asynchronous reset mid-run, checked before the next clock edge
        #2;
        rstn = 1'b0;
        #1;
        check("arst_q", 32'(q), 32'h0);
        check("arst_qv", 32'(q_valid), 32'h0);
        check("arst_mis", 32'(mis), 32'h0);
        check("arst_cnt_c", 32'(cnt_c), 32'h0);
        check("arst_fault", 32'(fault), 32'h0);
        check("arst_stateC", 32'(dut.u_mon_c.r_state), 32'(TRK_OK));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/voter_tmr_monitor.md
# voter_tmr_monitor

Registered, parametrised triple-modular-redundancy voter with per-replica fault monitoring, for the PLL and other TMR-protected configuration and state registers. It takes three replica words, outputs the bitwise 2-of-3 majority one cycle later, and tracks which replica disagrees. Per-replica error counters and a persistent-fault state machine let slow control tell a transient upset from a stuck replica.

## Interface
Parameters:
- `WIDTH`, default 6: voted word width, must be ≥1.
- `CNT_WIDTH`, default 8: width of each saturating error counter.
- `PERSIST`, default 4: consecutive mismatching enabled cycles that declare a replica faulty, must be ≥1.

Ports:
- `clk` input 1: single clock for the block.
- `rstn` input 1: asynchronous, active-low reset.
- `en` input 1: sample enable; inputs are voted and monitored only when high.
- `clr` input 1: synchronous clear of counters, fault flags and tracker states.
- `A`, `B`, `C` input WIDTH: replica words.
- `Q` output WIDTH: registered bitwise majority.
- `q_valid` output 1: high the cycle after an enabled sample.
- `mis` output 3: registered per-replica mismatch, aligned with `Q`. Bit 2 is A, bit 1 is B, bit 0 is C.
- `multi` output 1: registered; high when ≥2 replicas mismatched in the same sample.
- `err_cnt_a`, `err_cnt_b`, `err_cnt_c` output CNT_WIDTH: saturating mismatch counts.
- `fault` output 3: sticky persistent-fault flags, same bit order as `mis`.

## Operation
- Majority per bit: `maj = (A&B)|(A&C)|(B&C)`.
- A replica mismatches when its word differs from `maj` in any bit.
- `multi` is high when `mis` has ≥2 bits set. Bitwise voting still yields `Q`; `multi` only flags reduced margin.
- When `en` is high, `Q`, `mis` and `multi` load on the clock edge.
- When `en` is low, `Q` holds, `mis` and `multi` load 0, and counters and trackers hold.
- Counters: each replica's counter increments by 1 per enabled mismatching sample and saturates at 2^CNT_WIDTH−1 with no wrap.
- Tracker per replica, with states OK, SUSPECT and FAULT and a run counter of width $clog2(PERSIST+1):
  - OK + mismatch: run=1; go to FAULT if PERSIST==1, else to SUSPECT.
  - SUSPECT + mismatch: run+1; go to FAULT when run reaches PERSIST.
  - SUSPECT + enabled match: back to OK, run=0.
  - FAULT is sticky until `clr` or reset. `fault[i]` is high iff that tracker is in FAULT.
- Disabled cycles (`en`=0) do not break a SUSPECT run.
- `clr` takes priority over counting for counters, trackers and `fault` in the same cycle. `Q`, `mis` and `multi` still update if `en` is high.

## Timing
- Latency: inputs sampled at edge N appear on `Q`, `mis` and `multi` after edge N. `q_valid` asserts in the same cycle.
- `err_cnt_*` and `fault` reflect sample N after edge N, aligned with `mis`.
- Reset values: `Q`=0, `q_valid`=0, `mis`=0, `multi`=0, all `err_cnt_*`=0, `fault`=0, all trackers OK with run=0.
- Reset asserted mid-run clears everything asynchronously. Reset deassertion is synchronised externally.
- After `clr` at edge N, the outputs are 0 and OK; a mismatch sampled at edge N+1 counts from 1.

## Configuration
- `VOTER_ERR_CNT_EN`:
  - Defined: the three counters and the `err_cnt_*` ports exist.
  - Undefined: the counters are not compiled and the `err_cnt_*` ports tie to 0. Voting, `mis`, `multi` and the trackers are unchanged.

## Structure
- Package `voter_pkg`:
  - Tracker state typedef: OK=2'd0, SUSPECT=2'd1, FAULT=2'd2.
  - Replica index constants: IDX_A=2, IDX_B=1, IDX_C=0.
- Sub-module `voter_replica_mon`, instantiated three times. It holds one tracker, its run counter and the optional counter.
  - Inputs: `clk`, `rstn`, `en`, `clr`, `mis_i`.
  - Outputs: `fault_o`, `err_cnt_o`.
- The top level holds the majority logic, `Q`, `mis`, `multi` and `q_valid`.

## Test plan
- WIDTH=6. A=B=C=6'h2A with `en`=1 → next cycle `Q`=6'h2A, `q_valid`=1, `mis`=0, counters 0.
- A=6'h3F, B=C=6'h00 for one cycle → `Q`=6'h00, `mis`=3'b100, `err_cnt_a`=1, tracker A in SUSPECT, `fault`=0. Then an all-equal cycle returns tracker A to OK.
- PERSIST=4, B differs for 4 enabled cycles with an `en`=0 cycle inserted after the second → `fault`=3'b010 after the 4th enabled mismatch, `err_cnt_b`=4.
- A=6'h01, B=6'h02, C=6'h00 → `Q`=6'h00, `mis`=3'b110, `multi`=1.
- CNT_WIDTH=2, C mismatches for 6 cycles → `err_cnt_c` stays at 3. Then `clr`=1 with a mismatch in the same cycle → `err_cnt_c`=0 and `fault`=0, while `Q` updates.
- Assert `rstn`=0 mid-SUSPECT run → all outputs go to their reset values immediately, without waiting for a clock edge.
- Rebuild without `VOTER_ERR_CNT_EN` → `err_cnt_*` read 0 and the fault behaviour is identical.
